// File: rtl/mac_pkg.sv
// Shared types and helpers for the Q8.8 MAC layer sequencer.
// Used by mac_seq_ctrl and mac_sat_acc.
package mac_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT,
        ACC,
        WRITE,
        FIN
    } state_t;

    // Signed 16-bit add evaluated at 17 bits, clamped to the Q8.8 range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w_sum;
        w_sum = {a[15], a} + {b[15], b};
        if (w_sum[16:15] == 2'b01) begin
            return SAT_MAX;
        end else if (w_sum[16:15] == 2'b10) begin
            return SAT_MIN;
        end else begin
            return w_sum[15:0];
        end
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle between the layer sequencer and its environment
// (start/status, layer memories, MAC handshake, result buffer).
// master: the sequencer. slave: memories, MAC and host.
interface mac_seq_ctrl_if #(
    parameter int DW  = 16,
    parameter int IAW = 2,
    parameter int WAW = 3,
    parameter int OAW = 1
);
    logic           start;
    logic           busy;
    logic           done;
    logic           mem_rd;
    logic [IAW-1:0] in_addr;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  in_data;
    logic [DW-1:0]  w_data;
    logic           mac_start;
    logic [DW-1:0]  mac_in;
    logic [DW-1:0]  weight;
    logic           mac_done;
    logic [DW-1:0]  mac_out;
    logic           res_wr;
    logic [OAW-1:0] res_addr;
    logic [DW-1:0]  res_data;

    modport master (
        input  start, in_data, w_data, mac_done, mac_out,
        output busy, done, mem_rd, in_addr, w_addr, mac_start,
               mac_in, weight, res_wr, res_addr, res_data
    );

    modport slave (
        output start, in_data, w_data, mac_done, mac_out,
        input  busy, done, mem_rd, in_addr, w_addr, mac_start,
               mac_in, weight, res_wr, res_addr, res_data
    );
endinterface

// File: rtl/mac_sat_acc.sv
// Saturating Q8.8 accumulator with synchronous clear and enable.
// Clear wins over enable.
module mac_sat_acc
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_add,
    output logic [DW-1:0] o_acc
);

    logic [DW-1:0] r_acc;

    // Accumulator register: clear on new neuron, saturating add per term.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= sat_add16(r_acc, i_add);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Layer sequencer: walks N_OUT neurons x N_IN terms, fetches activation and
// weight, runs one MAC handshake per term and accumulates with saturation.
// Optional macro MAC_SEQ_RELU_EN applies ReLU to the written result.
module mac_seq_ctrl #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 16,
    parameter int IAW   = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int WAW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    parameter int OAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.master bus
);
    import mac_pkg::*;

    state_t         r_state;
    state_t         w_state_next;
    logic [IAW-1:0] r_i;
    logic [OAW-1:0] r_j;
    logic [WAW-1:0] r_waddr;
    logic [DW-1:0]  r_mac_in;
    logic [DW-1:0]  r_weight;
    logic [DW-1:0]  w_acc;
    logic [DW-1:0]  w_act;
    logic           w_last_term;
    logic           w_last_neuron;
    logic           w_acc_clr;
    logic           w_acc_en;

    assign w_last_term   = (r_i == IAW'(N_IN - 1));
    assign w_last_neuron = (r_j == OAW'(N_OUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_state_next  = r_state;
        w_acc_clr     = 1'b0;
        w_acc_en      = 1'b0;
        bus.busy      = 1'b1;
        bus.mem_rd    = 1'b0;
        bus.mac_start = 1'b0;
        bus.res_wr    = 1'b0;
        bus.done      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_acc_clr    = 1'b1;
                    w_state_next = READ;
                end
            end
            READ: begin
                bus.mem_rd   = 1'b1;
                w_state_next = ISSUE;
            end
            ISSUE: begin
                bus.mac_start = 1'b1;
                w_state_next  = WAIT;
            end
            WAIT: begin
                if (bus.mac_done) begin
                    w_state_next = ACC;
                end
            end
            ACC: begin
                w_acc_en     = 1'b1;
                w_state_next = w_last_term ? WRITE : READ;
            end
            WRITE: begin
                bus.res_wr   = 1'b1;
                w_acc_clr    = 1'b1;
                w_state_next = w_last_neuron ? FIN : READ;
            end
            FIN: begin
                bus.done     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Term/neuron counters; the weight address runs linearly so it always
    // equals j*N_IN + i without a multiplier.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_waddr <= '0;
                    end
                end
                ACC: begin
                    r_waddr <= r_waddr + WAW'(1);
                    if (!w_last_term) begin
                        r_i <= r_i + IAW'(1);
                    end
                end
                WRITE: begin
                    r_i <= '0;
                    if (!w_last_neuron) begin
                        r_j <= r_j + OAW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture: memory data is valid in ISSUE and held until the next ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mac_in <= '0;
            r_weight <= '0;
        end else if (r_state == ISSUE) begin
            r_mac_in <= bus.in_data;
            r_weight <= bus.w_data;
        end
    end

    mac_sat_acc u_acc (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_acc_clr),
        .i_en  (w_acc_en),
        .i_add (bus.mac_out),
        .o_acc (w_acc)
    );

`ifdef MAC_SEQ_RELU_EN
    assign w_act = w_acc[DW-1] ? '0 : w_acc;
`else
    assign w_act = w_acc;
`endif

    assign bus.in_addr  = r_i;
    assign bus.w_addr   = r_waddr;
    assign bus.res_addr = r_j;
    assign bus.mac_in   = r_mac_in;
    assign bus.weight   = r_weight;
    assign bus.res_data = bus.res_wr ? w_act : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: table of layer vectors on a 4x2
// instance plus hand sequences (glitches, mid-op reset) and a 3x3 address walk.
`timescale 1ns/1ps
module tb_mac_seq_ctrl;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int B_IN  = 3;
    localparam int B_OUT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.DW(16), .IAW(2), .WAW(3), .OAW(1)) bus_a ();
    mac_seq_ctrl_if #(.DW(16), .IAW(2), .WAW(4), .OAW(2)) bus_b ();

    mac_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(16), .IAW(2), .WAW(3), .OAW(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mac_seq_ctrl #(.N_IN(B_IN), .N_OUT(B_OUT), .DW(16), .IAW(2), .WAW(4), .OAW(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    // Memories and MAC model for instance A. The MAC raises mac_done two
    // cycles after it samples mac_start; mac_out comes from a per-term table.
    logic [15:0] act_mem [4];
    logic [15:0] w_mem   [8];
    logic [15:0] mac_tab [4];
    logic [2:0]  sr_a;
    logic [2:0]  sr_b;
    logic        inj_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_a          <= '0;
            bus_a.in_data <= '0;
            bus_a.w_data  <= '0;
        end else begin
            sr_a <= {sr_a[1:0], bus_a.mac_start};
            if (bus_a.mem_rd) begin
                bus_a.in_data <= act_mem[bus_a.in_addr];
                bus_a.w_data  <= w_mem[bus_a.w_addr];
            end
        end
    end
    assign bus_a.mac_done = sr_a[2] | inj_done;
    assign bus_a.mac_out  = mac_tab[bus_a.in_addr];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_b          <= '0;
            bus_b.in_data <= '0;
            bus_b.w_data  <= '0;
        end else begin
            sr_b <= {sr_b[1:0], bus_b.mac_start};
            if (bus_b.mem_rd) begin
                bus_b.in_data <= 16'(bus_b.in_addr);
                bus_b.w_data  <= 16'(bus_b.w_addr);
            end
        end
    end
    assign bus_b.mac_done = sr_b[2];
    assign bus_b.mac_out  = 16'h0100;

    typedef struct {
        string            name;
        logic [3:0][15:0] mac;
        logic [15:0]      raw;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input string nm, input logic [15:0] m0, input logic [15:0] m1,
                                input logic [15:0] m2, input logic [15:0] m3, input logic [15:0] raw);
        vec_t v;
        v.name   = nm;
        v.mac[0] = m0;
        v.mac[1] = m1;
        v.mac[2] = m2;
        v.mac[3] = m3;
        v.raw    = raw;
        return v;
    endfunction

    function automatic logic [15:0] act_model(input logic [15:0] x);
`ifdef MAC_SEQ_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {5'(0), bus_a.busy, bus_a.done, bus_a.mem_rd, bus_a.mac_start, bus_a.res_wr,
                bus_a.in_addr, bus_a.w_addr, bus_a.res_addr,
                bus_a.mac_in, bus_a.weight, bus_a.res_data};
    endfunction

    function automatic logic [63:0] outs_b();
        return {4'(0), bus_b.busy, bus_b.done, bus_b.mem_rd, bus_b.mac_start, bus_b.res_wr,
                bus_b.in_addr, bus_b.w_addr, bus_b.res_addr,
                bus_b.mac_in, bus_b.weight, bus_b.res_data};
    endfunction

    // One layer on instance A. glitch: mac_done in IDLE and READ, start in WAIT.
    // abort_at: assert reset in the WAIT following that mac_start (1-based), 0 = none.
    task automatic run_a(input int vi, input bit glitch, input int abort_at);
        int          starts;
        int          writes;
        int          op_i;
        int          op_j;
        bit          prev_ms;
        bit          in_wait;
        bit          got_done;
        bit          aborted;
        logic [15:0] exp_res;
        starts   = 0;
        writes   = 0;
        op_i     = 0;
        op_j     = 0;
        prev_ms  = 1'b0;
        got_done = 1'b0;
        aborted  = 1'b0;
        for (int k = 0; k < 4; k++) mac_tab[k] = vecs[vi].mac[k];
        exp_res = act_model(vecs[vi].raw);

        @(negedge clk);
        chk({vecs[vi].name, "_idle_busy"}, 64'(bus_a.busy), 64'd0);
        if (glitch) begin
            inj_done = 1'b1;
            @(negedge clk);
            inj_done = 1'b0;
            chk("glitch_idle_done_ignored", {62'd0, bus_a.busy, bus_a.mac_start}, 64'd0);
        end
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;

        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            in_wait = prev_ms;
            if (in_wait) begin
                chk({vecs[vi].name, "_mac_in"}, 64'(bus_a.mac_in), 64'(act_mem[op_i]));
                chk({vecs[vi].name, "_weight"}, 64'(bus_a.weight), 64'(w_mem[op_j * N_IN + op_i]));
            end
            if (bus_a.mac_start) begin
                op_i = starts % N_IN;
                op_j = starts / N_IN;
                chk({vecs[vi].name, "_issue_addr"}, {32'(bus_a.in_addr), 32'(bus_a.w_addr)},
                    {32'(op_i), 32'(op_j * N_IN + op_i)});
                starts++;
            end
            prev_ms = bus_a.mac_start;
            if (bus_a.res_wr) begin
                $display("A %s write addr=%0d data=%h", vecs[vi].name, bus_a.res_addr, bus_a.res_data);
                chk({vecs[vi].name, "_res_addr"}, 64'(bus_a.res_addr), 64'(writes));
                chk({vecs[vi].name, "_res_data"}, 64'(bus_a.res_data), 64'(exp_res));
                writes++;
            end
            if (glitch) begin
                bus_a.start = in_wait && (starts == 3);
                inj_done    = bus_a.mem_rd && (starts == 1);
            end
            if (abort_at != 0 && in_wait && starts == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_outputs_zero", outs_a(), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (bus_a.done) begin
                chk({vecs[vi].name, "_latency"}, 64'(cyc + 1), 64'd51);
                got_done = 1'b1;
                break;
            end
        end
        bus_a.start = 1'b0;
        inj_done    = 1'b0;

        if (!aborted) begin
            if (!got_done) begin
                chk({vecs[vi].name, "_done_timeout"}, 64'd0, 64'd1);
            end else begin
                @(negedge clk);
                chk({vecs[vi].name, "_done_pulse_end"}, {62'd0, bus_a.done, bus_a.busy}, 64'd0);
            end
            chk({vecs[vi].name, "_writes"}, 64'(writes), 64'(N_OUT));
            chk({vecs[vi].name, "_starts"}, 64'(starts), 64'(N_IN * N_OUT));
            $display("A layer %s: starts=%0d writes=%0d", vecs[vi].name, starts, writes);
        end else begin
            $display("A layer %s: aborted by reset after %0d starts", vecs[vi].name, starts);
        end
    endtask

    // 3x3 address walk on instance B.
    task automatic run_b();
        int rds;
        int wrs;
        bit got_done;
        rds      = 0;
        wrs      = 0;
        got_done = 1'b0;
        @(negedge clk);
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus_b.mem_rd) begin
                chk("b_w_addr", 64'(bus_b.w_addr), 64'(rds));
                chk("b_in_addr", 64'(bus_b.in_addr), 64'(rds % B_IN));
                rds++;
            end
            if (bus_b.res_wr) begin
                $display("B write addr=%0d data=%h", bus_b.res_addr, bus_b.res_data);
                chk("b_res_addr", 64'(bus_b.res_addr), 64'(wrs));
                chk("b_res_data", 64'(bus_b.res_data), 64'h0300);
                wrs++;
            end
            if (bus_b.done) begin
                chk("b_latency", 64'(cyc + 1), 64'd58);
                got_done = 1'b1;
                break;
            end
        end
        if (!got_done) chk("b_done_timeout", 64'd0, 64'd1);
        chk("b_reads", 64'(rds), 64'(B_IN * B_OUT));
        chk("b_writes", 64'(wrs), 64'(B_OUT));
        $display("B layer 3x3: reads=%0d writes=%0d", rds, wrs);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) act_mem[k] = 16'h0100 + 16'(k * 16);
        for (int k = 0; k < 8; k++) w_mem[k] = 16'h0100 + 16'(k);
        for (int k = 0; k < 4; k++) mac_tab[k] = 16'h0000;
        vecs[0] = mk("basic",   16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0400);
        vecs[1] = mk("sat_pos", 16'h7000, 16'h7000, 16'h0000, 16'h0000, 16'h7FFF);
        vecs[2] = mk("sat_neg", 16'h9000, 16'h9000, 16'h0000, 16'h0000, 16'h8000);
        vecs[3] = mk("act_neg", 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFE00);
        vecs[4] = mk("mixed",   16'h7000, 16'h7000, 16'h9000, 16'h0100, 16'h10FF);
        vecs[5] = mk("recover", 16'h8000, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000);

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        inj_done    = 1'b0;

        #1 reset = 1'b0;
        #1;
        chk("reset_outputs_a", outs_a(), 64'd0);
        chk("reset_outputs_b", outs_b(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int vi = 0; vi < 6; vi++) run_a(vi, 1'b0, 0);

        run_a(0, 1'b1, 0);

        run_a(0, 1'b0, 7);
        @(negedge clk);
        chk("abort_hold_zero", outs_a(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_a(0, 1'b0, 0);

        run_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
